sma_stream: RTL and testbench



---
 rtl/sma_stream_if.sv | 41 ++++
 rtl/sma_stream.sv | 147 ++++++++++++++
 tb/tb_sma_stream.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/sma_stream_if.sv
// Sample-in / average-out bundle for the streaming moving-average filter.
// Latency: n/a (wiring only); the filter output is registered, one clock after accept.
// Backpressure: the x side uses valid/ready; the y side has none (valid pulse only).
//
// Signals:
//   x_valid  source -> filter  sample offered
//   x        source -> filter  signed sample, DATA_W bits
//   x_ready  filter -> source  filter can take a sample this cycle
//   y_valid  filter -> sink    one-cycle pulse, y carries a fresh average
//   y        filter -> sink    signed average, held between pulses
//   primed   filter -> sink    window completely filled since the last clear/reset
interface sma_stream_if #(
    parameter int DATA_W = 16
);
    logic                     x_valid;
    logic signed [DATA_W-1:0] x;
    logic                     x_ready;
    logic                     y_valid;
    logic signed [DATA_W-1:0] y;
    logic                     primed;

    // Sample source / result consumer side.
    modport master (
        output x_valid,
        output x,
        input  x_ready,
        input  y_valid,
        input  y,
        input  primed
    );

    // Filter side.
    modport slave (
        input  x_valid,
        input  x,
        output x_ready,
        output y_valid,
        output y,
        output primed
    );
endinterface

// File: rtl/sma_stream.sv
// Streaming simple moving average over the last 2**LOG2_DEPTH accepted samples.
// Latency: 1 clk from the accept edge to y/y_valid; one result per accepted sample.
// Backpressure: x_ready low only while the history is being flushed; no output backpressure.
//
// Ports:
//   clk    clock, everything on the rising edge
//   rst    synchronous active-high reset: flush history, zero y, drop primed
//   clear  synchronous pulse: flush history like rst but keep y
//   s      sma_stream_if.slave: x_valid/x/x_ready in, y_valid/y/primed out
module sma_stream #(
    parameter int DATA_W     = 16,
    parameter int LOG2_DEPTH = 2,
    parameter int ROUND_MODE = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    sma_stream_if.slave  s
);
    localparam int N     = 1 << LOG2_DEPTH;
    // Sum of N DATA_W-bit signed samples never needs more than LOG2_DEPTH extra bits.
    localparam int ACC_W = DATA_W + LOG2_DEPTH;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    localparam logic [LOG2_DEPTH:0]          CNT_FULL  = (LOG2_DEPTH+1)'(N);
    localparam logic [LOG2_DEPTH-1:0]        WP_LAST   = LOG2_DEPTH'(N - 1);
    // Bias added before the arithmetic shift: N-1 turns floor into truncation for
    // negative sums; N/2 gives round-half-up.
    localparam logic signed [ACC_W-1:0]      BIAS_TRUNC = ACC_W'(N - 1);
    localparam logic signed [ACC_W-1:0]      BIAS_HALF  = ACC_W'(N / 2);

    logic [0:0]               state_q, state_d;
    logic [LOG2_DEPTH-1:0]    wp_q, wp_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [LOG2_DEPTH:0]      cnt_q, cnt_d;
    logic                     primed_q, primed_d;
    logic signed [DATA_W-1:0] y_q, y_d;
    logic                     y_valid_q, y_valid_d;

    logic signed [DATA_W-1:0] hist_q [N];
    logic                     hist_we;
    logic signed [DATA_W-1:0] hist_wdat;

    logic                     accept;
    logic signed [ACC_W-1:0]  x_ext;
    logic signed [ACC_W-1:0]  old_ext;
    logic signed [ACC_W-1:0]  sum_new;
    logic signed [ACC_W-1:0]  bias;
    logic signed [ACC_W-1:0]  biased;

    assign s.x_ready = (state_q == ST_RUN);
    assign s.y_valid = y_valid_q;
    assign s.y       = y_q;
    assign s.primed  = primed_q;

    always_comb begin
        state_d   = state_q;
        wp_d      = wp_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        primed_d  = primed_q;
        y_d       = y_q;
        y_valid_d = 1'b0;
        hist_we   = 1'b0;
        hist_wdat = '0;

        x_ext   = {{LOG2_DEPTH{s.x[DATA_W-1]}}, s.x};
        old_ext = {{LOG2_DEPTH{hist_q[wp_q][DATA_W-1]}}, hist_q[wp_q]};
        // Running sum after replacing the oldest sample with the incoming one.
        sum_new = acc_q + x_ext - old_ext;

        if (ROUND_MODE == 1) begin
            bias = BIAS_HALF;
        end else begin
            bias = sum_new[ACC_W-1] ? BIAS_TRUNC : '0;
        end
        biased = sum_new + bias;

        // A clear wins over a simultaneous transfer; the offered sample is dropped.
        accept = (state_q == ST_RUN) && s.x_valid && !clear;

        if (clear) begin
            state_d  = ST_CLEAR;
            wp_d     = '0;
            acc_d    = '0;
            cnt_d    = '0;
            primed_d = 1'b0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    // Zero one history slot per cycle; leave once the pointer wraps.
                    hist_we = 1'b1;
                    wp_d    = wp_q + 1'b1;
                    if (wp_q == WP_LAST) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        hist_we   = 1'b1;
                        hist_wdat = s.x;
                        wp_d      = wp_q + 1'b1;
                        acc_d     = sum_new;
                        cnt_d     = (cnt_q == CNT_FULL) ? cnt_q : cnt_q + 1'b1;
                        primed_d  = (cnt_d == CNT_FULL);
                        // The quotient always fits DATA_W; the upper bits are sign copies.
                        y_d       = DATA_W'(biased >>> LOG2_DEPTH);
                        y_valid_d = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_CLEAR;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_CLEAR;
            wp_q      <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            primed_q  <= 1'b0;
            y_q       <= '0;
            y_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wp_q      <= wp_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            primed_q  <= primed_d;
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
        end
    end

    // History needs no reset of its own: the CLEAR state rewrites every slot
    // before any sample can be accepted.
    always_ff @(posedge clk) begin
        if (hist_we && !rst) begin
            hist_q[wp_q] <= hist_wdat;
        end
    end
endmodule

// File: tb/tb_sma_stream.sv
// Bench for sma_stream: truncating and round-half-up instances driven in lockstep.
// Latency: results checked #1 after the edge on which the vector is applied.
// Backpressure: vectors are timed to the 4-cycle flush; one bounded wait for x_ready.
module tb_sma_stream;
    localparam int DW = 16;

    logic clk;
    logic rst;
    logic clear;
    logic x_valid;
    logic signed [DW-1:0] x;

    int checks;
    int failures;

    sma_stream_if #(.DATA_W(DW)) if0 ();
    sma_stream_if #(.DATA_W(DW)) if1 ();

    assign if0.x_valid = x_valid;
    assign if0.x       = x;
    assign if1.x_valid = x_valid;
    assign if1.x       = x;

    sma_stream #(.DATA_W(DW), .LOG2_DEPTH(2), .ROUND_MODE(0)) dut0 (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .s     (if0)
    );

    sma_stream #(.DATA_W(DW), .LOG2_DEPTH(2), .ROUND_MODE(1)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .s     (if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic                 r;
        logic                 c;
        logic                 v;
        logic signed [DW-1:0] xi;
        logic                 yv;
        logic signed [DW-1:0] y0;
        logic signed [DW-1:0] y1;
        logic                 pr;
        logic                 rdy;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic r, input logic c, input logic v, input int xi,
                       input logic yv, input int y0, input int y1,
                       input logic pr, input logic rdy);
        vec_t e;
        e.r = r; e.c = c; e.v = v; e.xi = DW'(xi);
        e.yv = yv; e.y0 = DW'(y0); e.y1 = DW'(y1); e.pr = pr; e.rdy = rdy;
        vq.push_back(e);
    endtask

    task automatic chk(input string name, input int idx,
                       input logic signed [31:0] act, input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s vec=%0d got=%0d want=%0d", name, idx, act, exp);
        end
    endtask

    // Flush sequence after a clear/rst vector: three more not-ready cycles, then ready.
    task automatic add_flush(input int yh);
        for (int k = 0; k < 3; k++) add(0, 0, 1, 7, 0, yh, yh, 0, 0);
        add(0, 0, 1, 7, 0, yh, yh, 0, 1);
    endtask

    initial begin
        int cyc;
        logic saw_yv;

        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        clear    = 1'b0;
        x_valid  = 1'b0;
        x        = '0;

        // Reset and initial flush: x_ready low for four cycles, outputs quiet.
        add(1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) add(0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 1);
        // Ramp of 100s; primed with the fourth result.
        add(0, 0, 1, 100, 1, 25, 25, 0, 1);
        add(0, 0, 1, 100, 1, 50, 50, 0, 1);
        add(0, 0, 1, 100, 1, 75, 75, 0, 1);
        add(0, 0, 1, 100, 1, 100, 100, 1, 1);
        add(0, 0, 1, 100, 1, 100, 100, 1, 1);
        // Clear with a simultaneous offered sample: dropped, y held.
        add(0, 1, 1, 5, 0, 100, 100, 0, 0);
        add_flush(100);
        // Small negative sum: truncation gives 0, round-half-up gives -1.
        add(0, 0, 1, -3, 1, 0, -1, 0, 1);
        add(0, 0, 1, 0, 1, 0, -1, 0, 1);
        add(0, 0, 1, 0, 1, 0, -1, 0, 1);
        add(0, 0, 1, 0, 1, 0, -1, 1, 1);
        // Full-scale positive then negative: no wrap.
        add(0, 0, 1, 32767, 1, 8191, 8192, 1, 1);
        add(0, 0, 1, 32767, 1, 16383, 16384, 1, 1);
        add(0, 0, 1, 32767, 1, 24575, 24575, 1, 1);
        add(0, 0, 1, 32767, 1, 32767, 32767, 1, 1);
        add(0, 0, 1, -32768, 1, 16383, 16383, 1, 1);
        add(0, 0, 1, -32768, 1, 0, 0, 1, 1);
        add(0, 0, 1, -32768, 1, -16384, -16384, 1, 1);
        add(0, 0, 1, -32768, 1, -32768, -32768, 1, 1);
        add(0, 1, 1, 5, 0, -32768, -32768, 0, 0);
        add_flush(-32768);
        // 1..6 with valid gaps; y holds across gaps.
        add(0, 0, 1, 1, 1, 0, 0, 0, 1);
        add(0, 0, 0, 99, 0, 0, 0, 0, 1);
        add(0, 0, 1, 2, 1, 0, 1, 0, 1);
        add(0, 0, 0, 99, 0, 0, 1, 0, 1);
        add(0, 0, 0, 99, 0, 0, 1, 0, 1);
        add(0, 0, 1, 3, 1, 1, 2, 0, 1);
        add(0, 0, 1, 4, 1, 2, 3, 1, 1);
        add(0, 0, 0, 99, 0, 2, 3, 1, 1);
        add(0, 0, 1, 5, 1, 3, 4, 1, 1);
        add(0, 0, 1, 6, 1, 4, 5, 1, 1);
        // Prime with 400s, clear mid-stream, restart with 8.
        add(0, 0, 1, 400, 1, 103, 104, 1, 1);
        add(0, 0, 1, 400, 1, 202, 203, 1, 1);
        add(0, 0, 1, 400, 1, 301, 302, 1, 1);
        add(0, 0, 1, 400, 1, 400, 400, 1, 1);
        add(0, 1, 1, 400, 0, 400, 400, 0, 0);
        add_flush(400);
        add(0, 0, 1, 8, 1, 2, 2, 0, 1);
        add(0, 0, 1, 400, 1, 102, 102, 0, 1);
        // rst together with clear: rst wins, y returns to 0.
        add(1, 1, 1, 400, 0, 0, 0, 0, 0);
        add_flush(0);
        add(0, 0, 1, 4, 1, 1, 1, 0, 1);

        for (int i = 0; i < vq.size(); i++) begin
            rst     = vq[i].r;
            clear   = vq[i].c;
            x_valid = vq[i].v;
            x       = vq[i].xi;
            @(posedge clk);
            #1;
            chk("y_valid0", i, 32'(if0.y_valid), 32'(vq[i].yv));
            chk("y0",       i, if0.y,           vq[i].y0);
            chk("primed0",  i, 32'(if0.primed), 32'(vq[i].pr));
            chk("x_ready0", i, 32'(if0.x_ready), 32'(vq[i].rdy));
            chk("y_valid1", i, 32'(if1.y_valid), 32'(vq[i].yv));
            chk("y1",       i, if1.y,           vq[i].y1);
        end

        // Clear while the source keeps offering 12: count not-ready cycles,
        // then the held sample goes through once ready returns.
        rst     = 1'b0;
        clear   = 1'b1;
        x_valid = 1'b1;
        x       = 16'sd12;
        @(posedge clk);
        #1;
        clear  = 1'b0;
        cyc    = 0;
        saw_yv = 1'b0;
        while (!if0.x_ready && cyc < 20) begin
            if (if0.y_valid || if1.y_valid) saw_yv = 1'b1;
            cyc++;
            @(posedge clk);
            #1;
        end
        chk("flush_cycles", 0, cyc, 4);
        chk("flush_no_yv",  0, 32'(saw_yv), 0);
        chk("flush_y_hold", 0, if0.y, 1);
        chk("flush_rdy1",   0, 32'(if1.x_ready), 1);
        @(posedge clk);
        #1;
        x_valid = 1'b0;
        chk("held_yv0", 0, 32'(if0.y_valid), 1);
        chk("held_y0",  0, if0.y, 3);
        chk("held_y1",  0, if1.y, 3);
        @(posedge clk);
        #1;
        chk("idle_yv0", 0, 32'(if0.y_valid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
